// File: rtl/neuromorphic_x1_initiator.sv
// Valid/ready initiator for the NEUROMORPHIC_X1 functional port: issues one macro access
// at a time, waits for func_ack, and returns the result. A watchdog aborts accesses that never complete.
module neuromorphic_x1_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_W           = 11
) (
    input  logic        CLKin,
    input  logic        RSTin,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  err_count,
    output logic        EN,
    output logic        R_WB,
    output logic [31:0] AD,
    output logic [31:0] DI,
    output logic [3:0]  SEL,
    input  logic [31:0] DO,
    input  logic        func_ack
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    state_e          state_q;
    logic            req_ready_q;
    logic            en_q;
    logic            r_wb_q;
    logic [31:0]     ad_q;
    logic [31:0]     di_q;
    logic [3:0]      sel_q;
    logic            rsp_valid_q;
    logic            rsp_err_q;
    logic [31:0]     rsp_rdata_q;
    logic [7:0]      err_count_q;
    logic [TO_W-1:0] wd_q;

    logic [TO_W-1:0] wd_d;
    logic [7:0]      err_count_d;
    logic            wd_expired;

    // The access is aborted on the edge whose increment would bring the count to the limit.
    assign wd_d        = wd_q + 1'b1;
    assign wd_expired  = (TIMEOUT_CYCLES != 0) && (wd_d == TO_LIMIT);
    assign err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLKin or negedge RSTin) begin
        if (!RSTin) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            en_q        <= 1'b0;
            r_wb_q      <= 1'b0;
            ad_q        <= '0;
            di_q        <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            err_count_q <= '0;
            wd_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        ad_q        <= req_addr;
                        di_q        <= req_wdata;
                        sel_q       <= req_sel;
                        r_wb_q      <= ~req_we;
                        en_q        <= 1'b1;
                        wd_q        <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack on the expiry edge still completes the access normally.
                    if (func_ack) begin
                        en_q        <= 1'b0;
                        rsp_rdata_q <= r_wb_q ? DO : 32'h0;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else if (wd_expired) begin
                        en_q        <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        err_count_q <= err_count_d;
                        state_q     <= RESP;
                    end else begin
                        wd_q <= wd_d;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    en_q        <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign err_count = err_count_q;
    assign EN        = en_q;
    assign R_WB      = r_wb_q;
    assign AD        = ad_q;
    assign DI        = di_q;
    assign SEL       = sel_q;

endmodule

// File: tb/tb_neuromorphic_x1_initiator.sv
// Directed bench for neuromorphic_x1_initiator: write, read, timeout, backpressure,
// reset during an access and err_count saturation, with hand-computed expectations.
module tb_neuromorphic_x1_initiator;

    logic        CLKin = 1'b0;
    logic        RSTin = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  err_count;
    logic        EN;
    logic        R_WB;
    logic [31:0] AD;
    logic [31:0] DI;
    logic [3:0]  SEL;
    logic [31:0] DO = '0;
    logic        func_ack = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    neuromorphic_x1_initiator #(.TIMEOUT_CYCLES(8), .TO_W(11)) dut (
        .CLKin(CLKin), .RSTin(RSTin),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .err_count(err_count),
        .EN(EN), .R_WB(R_WB), .AD(AD), .DI(DI), .SEL(SEL),
        .DO(DO), .func_ack(func_ack)
    );

    always #5 CLKin = ~CLKin;

    // Advance one rising edge and settle before sampling or driving.
    task automatic tick;
        @(posedge CLKin);
        #1;
    endtask

    task automatic test_reset;
        RSTin = 1'b0;
        #12;
        n_cmp++;
        if ({req_ready, EN, R_WB, rsp_valid, rsp_err} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 10000", {req_ready, EN, R_WB, rsp_valid, rsp_err});
        end
        n_cmp++;
        if ({AD, DI, SEL, rsp_rdata, err_count} !== 108'h0) begin
            n_bad++;
            $display("FAIL reset_data: got AD=%h DI=%h SEL=%h rdata=%h errcnt=%0d want all 0",
                     AD, DI, SEL, rsp_rdata, err_count);
        end
        @(negedge CLKin);
        RSTin = 1'b1;
        tick();
        n_cmp++;
        if (req_ready !== 1'b1 || EN !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: got req_ready=%b EN=%b want 1/0", req_ready, EN);
        end
    endtask

    task automatic test_write;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10;
        req_wdata = 32'hDEADBEEF; req_sel = 4'hF; DO = 32'h12345678;
        tick();
        req_valid = 1'b0;
        n_cmp++;
        if ({EN, R_WB, req_ready} !== 3'b100 || AD !== 32'h10 || DI !== 32'hDEADBEEF || SEL !== 4'hF) begin
            n_bad++;
            $display("FAIL wr_issue: got EN=%b R_WB=%b rdy=%b AD=%h DI=%h SEL=%h want 1/0/0/10/deadbeef/f",
                     EN, R_WB, req_ready, AD, DI, SEL);
        end
        for (int c = 1; c <= 2; c++) begin
            tick();
            n_cmp++;
            if (EN !== 1'b1 || rsp_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL wr_busy_c%0d: got EN=%b rsp_valid=%b want 1/0", c, EN, rsp_valid);
            end
        end
        func_ack = 1'b1;
        tick();
        func_ack = 1'b0;
        n_cmp++;
        if ({EN, rsp_valid, rsp_err} !== 3'b010 || rsp_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL wr_resp: got EN=%b valid=%b err=%b rdata=%h want 0/1/0/0",
                     EN, rsp_valid, rsp_err, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_done: got valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_read;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_sel = 4'hF;
        tick();
        req_valid = 1'b0;
        n_cmp++;
        if (EN !== 1'b1 || R_WB !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_issue: got EN=%b R_WB=%b valid=%b want 1/1/0", EN, R_WB, rsp_valid);
        end
        func_ack = 1'b1; DO = 32'hDEADBEEF;
        tick();
        func_ack = 1'b0; DO = 32'h0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0 || EN !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_resp: got valid=%b rdata=%h err=%b EN=%b want 1/deadbeef/0/0",
                     rsp_valid, rsp_rdata, rsp_err, EN);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; DO = 32'hAAAA5555;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            n_cmp++;
            if (EN !== 1'b1 || rsp_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL to_busy_c%0d: got EN=%b valid=%b want 1/0", c, EN, rsp_valid);
            end
        end
        tick();
        n_cmp++;
        if ({EN, rsp_valid, rsp_err} !== 3'b011 || rsp_rdata !== 32'h0 || err_count !== 8'd1) begin
            n_bad++;
            $display("FAIL to_abort: got EN=%b valid=%b err=%b rdata=%h errcnt=%0d want 0/1/1/0/1",
                     EN, rsp_valid, rsp_err, rsp_rdata, err_count);
        end
        tick();
        tick();
        func_ack = 1'b1;
        tick();
        func_ack = 1'b0;
        n_cmp++;
        if ({EN, rsp_valid, rsp_err} !== 3'b011 || rsp_rdata !== 32'h0 || err_count !== 8'd1) begin
            n_bad++;
            $display("FAIL to_late_ack: got EN=%b valid=%b err=%b rdata=%h errcnt=%0d want 0/1/1/0/1",
                     EN, rsp_valid, rsp_err, rsp_rdata, err_count);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        func_ack = 1'b1;
        tick();
        func_ack = 1'b0;
        DO = 32'h0;
        n_cmp++;
        if ({EN, rsp_valid, rsp_err, req_ready} !== 4'b0001 || err_count !== 8'd1) begin
            n_bad++;
            $display("FAIL to_idle_ack: got EN=%b valid=%b err=%b rdy=%b errcnt=%0d want 0/0/0/1/1",
                     EN, rsp_valid, rsp_err, req_ready, err_count);
        end
    endtask

    task automatic test_backpressure;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h30;
        tick();
        func_ack = 1'b1; DO = 32'h0BADF00D;
        tick();
        func_ack = 1'b0; DO = 32'h0;
        // Next command waits on the request channel while the response is held.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h44; req_wdata = 32'h55AA55AA; req_sel = 4'h0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            n_cmp++;
            if ({rsp_valid, rsp_err, req_ready, EN} !== 4'b1000 || rsp_rdata !== 32'h0BADF00D) begin
                n_bad++;
                $display("FAIL bp_hold_c%0d: got valid=%b err=%b rdy=%b EN=%b rdata=%h want 1/0/0/0/0badf00d",
                         c, rsp_valid, rsp_err, req_ready, EN, rsp_rdata);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_cmp++;
        if ({rsp_valid, req_ready, EN} !== 3'b010) begin
            n_bad++;
            $display("FAIL bp_release: got valid=%b rdy=%b EN=%b want 0/1/0", rsp_valid, req_ready, EN);
        end
        tick();
        req_valid = 1'b0;
        n_cmp++;
        if (EN !== 1'b1 || R_WB !== 1'b0 || AD !== 32'h44 || DI !== 32'h55AA55AA || SEL !== 4'h0) begin
            n_bad++;
            $display("FAIL bp_accept: got EN=%b R_WB=%b AD=%h DI=%h SEL=%h want 1/0/44/55aa55aa/0",
                     EN, R_WB, AD, DI, SEL);
        end
        func_ack = 1'b1;
        tick();
        func_ack = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_sel0_resp: got valid=%b rdata=%h err=%b want 1/0/0", rsp_valid, rsp_rdata, rsp_err);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_busy;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h99;
        tick();
        req_valid = 1'b0;
        tick();
        n_cmp++;
        if (EN !== 1'b1 || AD !== 32'h99) begin
            n_bad++;
            $display("FAIL rst_pre: got EN=%b AD=%h want 1/99", EN, AD);
        end
        RSTin = 1'b0;
        #1;
        n_cmp++;
        if ({EN, rsp_valid, req_ready} !== 3'b001 || AD !== 32'h0 || err_count !== 8'd0) begin
            n_bad++;
            $display("FAIL rst_async: got EN=%b valid=%b rdy=%b AD=%h errcnt=%0d want 0/0/1/0/0",
                     EN, rsp_valid, req_ready, AD, err_count);
        end
        @(negedge CLKin);
        RSTin = 1'b1;
        func_ack = 1'b1; DO = 32'hFFFF0000; rsp_ready = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            func_ack = 1'b0;
            n_cmp++;
            if ({rsp_valid, EN, req_ready} !== 3'b001) begin
                n_bad++;
                $display("FAIL rst_no_stale_c%0d: got valid=%b EN=%b rdy=%b want 0/0/1", c, rsp_valid, EN, req_ready);
            end
        end
        rsp_ready = 1'b0; DO = 32'h0;
    endtask

    task automatic test_saturation;
        int lat;
        for (int k = 1; k <= 260; k++) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = k;
            tick();
            req_valid = 1'b0;
            lat = 0;
            while (rsp_valid !== 1'b1 && lat < 20) begin
                tick();
                lat++;
            end
            n_cmp++;
            if (lat != 8 || rsp_err !== 1'b1) begin
                n_bad++;
                $display("FAIL sat_abort_%0d: got latency=%0d err=%b want 8/1", k, lat, rsp_err);
            end
            n_cmp++;
            if (err_count !== 8'((k > 255) ? 255 : k)) begin
                n_bad++;
                $display("FAIL sat_count_%0d: got %0d want %0d", k, err_count, (k > 255) ? 255 : k);
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_backpressure();
        test_reset_mid_busy();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
